ysyx_22050612_lsu: RTL



---
 rtl/ysyx_22050612_lsu_if.sv | 44 ++++
 rtl/ysyx_22050612_lsu.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ysyx_22050612_lsu_if.sv
// Request, memory and write-back signal bundle for ysyx_22050612_lsu.
// The LSU connects through the slave modport; the surrounding pipeline uses master.
interface ysyx_22050612_lsu_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic        in_wen;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;

  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_rd;
  logic        out_misalign;

  modport slave (
    input  in_valid, in_addr, in_wdata, in_wen, in_funct3, in_rd,
    output in_ready,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output out_valid, out_data, out_rd, out_misalign,
    input  out_ready
  );

  modport master (
    output in_valid, in_addr, in_wdata, in_wen, in_funct3, in_rd,
    input  in_ready,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  out_valid, out_data, out_rd, out_misalign,
    output out_ready
  );
endinterface

// File: rtl/ysyx_22050612_lsu.sv
// RV64 load/store unit: one access at a time, store lane shifting, load align/extend.
// Define YSYX_22050612_LSU_MISALIGN_CHECK_EN to trap misaligned ops without a memory access.
module ysyx_22050612_lsu (
  input logic                  clk,
  input logic                  rst,
  ysyx_22050612_lsu_if.slave   lsu
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [63:0] addr_q, wdata_q;
  logic        wen_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic [63:0] data_q, data_d;
  logic        misalign_q, misalign_d;

  logic        accept;
  logic        acc_misalign;
  logic [2:0]  off;
  logic [7:0]  size_mask;
  logic [15:0] wmask_full;
  logic [63:0] shifted;
  logic [63:0] load_data;

  assign accept = (state_q == StIdle) && lsu.in_valid;

`ifdef YSYX_22050612_LSU_MISALIGN_CHECK_EN
  always_comb begin
    acc_misalign = 1'b0;
    case (lsu.in_funct3[1:0])
      2'b01:   acc_misalign = lsu.in_addr[0];
      2'b10:   acc_misalign = |lsu.in_addr[1:0];
      2'b11:   acc_misalign = |lsu.in_addr[2:0];
      default: acc_misalign = 1'b0;
    endcase
  end
`else
  assign acc_misalign = 1'b0;
`endif

  assign off = addr_q[2:0];

  always_comb begin
    size_mask = 8'hff;
    case (funct3_q[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0f;
      default: size_mask = 8'hff;
    endcase
  end

  // Bytes that spill past the 8-byte word land in the upper half and are dropped.
  assign wmask_full = {8'h00, size_mask} << off;

  assign lsu.in_ready      = (state_q == StIdle);
  assign lsu.mem_req_valid = (state_q == StReq);
  assign lsu.mem_addr      = {addr_q[63:3], 3'b000};
  assign lsu.mem_wen       = wen_q;
  assign lsu.mem_wmask     = wen_q ? wmask_full[7:0] : 8'h00;
  assign lsu.mem_wdata     = wen_q ? (wdata_q << {off, 3'b000}) : 64'h0;
  assign lsu.out_valid     = (state_q == StDone);
  assign lsu.out_data      = data_q;
  assign lsu.out_rd        = rd_q;
  assign lsu.out_misalign  = misalign_q;

  // Logical shift fills zeros above the word end before extension.
  assign shifted = lsu.mem_rdata >> {off, 3'b000};

  always_comb begin
    load_data = shifted;
    case (funct3_q)
      3'b000:  load_data = {{56{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  load_data = {56'h0, shifted[7:0]};
      3'b101:  load_data = {48'h0, shifted[15:0]};
      3'b110:  load_data = {32'h0, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    misalign_d = misalign_q;
    case (state_q)
      StIdle: begin
        if (lsu.in_valid) begin
          misalign_d = acc_misalign;
          if (acc_misalign) begin
            data_d  = 64'h0;
            state_d = StDone;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (lsu.mem_req_ready) state_d = StWait;
      end
      StWait: begin
        if (lsu.mem_rsp_valid) begin
          data_d  = wen_q ? 64'h0 : load_data;
          state_d = StDone;
        end
      end
      StDone: begin
        if (lsu.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= 64'h0;
      wdata_q    <= 64'h0;
      wen_q      <= 1'b0;
      funct3_q   <= 3'b000;
      rd_q       <= 5'd0;
      data_q     <= 64'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      misalign_q <= misalign_d;
      if (accept) begin
        addr_q   <= lsu.in_addr;
        wdata_q  <= lsu.in_wdata;
        wen_q    <= lsu.in_wen;
        funct3_q <= lsu.in_funct3;
        rd_q     <= lsu.in_rd;
      end
    end
  end

endmodule
